img_window_collector: RTL

- Receiving end of the 3x3 window address sequencer.
- The sequencer walks linear pixel offsets 0,1,2,W,W+1,W+2,2W,2W+1,2W+2 with W = 640. Memory returns one pixel per offset.
- This block decodes each returned offset to a tap index and stores the pixel in that tap.
- When all 9 taps are present, it presents one packed 3x3 window to the downstream convolution stage using a valid/ready handshake.

---
 rtl/img_win_pkg.sv | 19 +
 rtl/img_tap_decode.sv | 26 ++
 rtl/img_window_collector.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/img_win_pkg.sv
// Shared types and tap geometry for the 3x3 window collector.
// Tap k sits at linear offset (k/3)*IMG_W + (k%3).
package img_win_pkg;

    localparam int NUM_TAPS = 9;
    localparam int PIX_W    = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef logic [NUM_TAPS-1:0][PIX_W-1:0] win_t;

    function automatic int tap_ofs(input int k, input int img_w);
        return (k / 3) * img_w + (k % 3);
    endfunction

endpackage

// File: rtl/img_tap_decode.sv
// Maps a returned linear offset to its 3x3 tap index.
// Pure equality compare against the nine tap offsets.
module img_tap_decode
    import img_win_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [3:0]        idx
);

    // Match the offset against every tap constant
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (addr == ADDR_W'(tap_ofs(k, IMG_W))) begin
                hit = 1'b1;
                idx = 4'(k);
            end
        end
    end

endmodule

// File: rtl/img_window_collector.sv
// Collects nine returned pixels into a 3x3 window and hands it downstream.
// Define WIN_SUM_EN to build the registered sum of all taps on win_sum.
module img_window_collector
    import img_win_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [ADDR_W-1:0]        pix_addr,
    input  logic [DATA_W-1:0]        pix_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [NUM_TAPS*DATA_W-1:0] win_data,
    output logic [DATA_W+3:0]        win_sum,
    output logic                     err_addr,
    input  logic                     err_clr
);

    logic                             hit;
    logic [3:0]                       idx;
    logic                             xfer;
    logic                             enter_hold;

    state_e                           state_q, state_d;
    logic [NUM_TAPS-1:0]              mask_q, mask_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0]  taps_q, taps_d;
    logic                             err_q, err_d;
    logic                             win_valid_q, win_valid_d;
    logic                             pix_ready_q, pix_ready_d;

    img_tap_decode #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr (pix_addr),
        .hit  (hit),
        .idx  (idx)
    );

    assign xfer      = pix_valid && pix_ready_q;
    assign pix_ready = pix_ready_q;
    assign win_valid = win_valid_q;
    assign win_data  = taps_q;
    assign err_addr  = err_q;

    // Next-state: fill taps while collecting, park the window until taken
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        taps_d      = taps_q;
        err_d       = err_q;
        win_valid_d = win_valid_q;
        pix_ready_d = pix_ready_q;
        enter_hold  = 1'b0;
        if (err_clr) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            COLLECT: begin
                if (xfer && hit) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (idx == 4'(k)) begin
                            taps_d[k] = pix_data;
                            mask_d[k] = 1'b1;
                        end
                    end
                    if (&mask_d) begin
                        state_d     = HOLD;
                        win_valid_d = 1'b1;
                        pix_ready_d = 1'b0;
                        enter_hold  = 1'b1;
                    end
                end else if (xfer) begin
                    err_d = 1'b1;
                end
            end
            HOLD: begin
                if (win_ready) begin
                    state_d     = COLLECT;
                    mask_d      = '0;
                    win_valid_d = 1'b0;
                    pix_ready_d = 1'b1;
                end
            end
        endcase
    end

    // Collector state, taps and handshake flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            taps_q      <= '0;
            err_q       <= 1'b0;
            win_valid_q <= 1'b0;
            pix_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            taps_q      <= taps_d;
            err_q       <= err_d;
            win_valid_q <= win_valid_d;
            pix_ready_q <= pix_ready_d;
        end
    end

`ifdef WIN_SUM_EN
    logic [DATA_W+3:0] sum_q, sum_d;

    // Sum of the completed window, captured on entry to HOLD
    always_comb begin
        sum_d = sum_q;
        if (enter_hold) begin
            sum_d = '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                sum_d = sum_d + (DATA_W+4)'(taps_d[k]);
            end
        end
    end

    // Window sum register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign win_sum = sum_q;
`else
    assign win_sum = '0;
`endif

endmodule
